ahb_lite_interconnect: RTL and testbench

AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

---
 rtl/ahb_lite_pkg.sv | 23 ++
 rtl/ahb_default_slave.sv | 54 +++++
 rtl/ahb_lite_interconnect.sv | 83 ++++++++
 tb/tb_ahb_lite_interconnect.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DEF_OKAY = 2'd0,
      DEF_ERR1 = 2'd1,
      DEF_ERR2 = 2'd2
   } def_state_e;

   // NONSEQ and SEQ carry data; IDLE and BUSY never need a response beyond OKAY.
   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle ERROR
// response and everything else with a zero-wait OKAY.
module ahb_default_slave
   import ahb_lite_pkg::*;
(
   input  logic       Hclk,
   input  logic       Hresetn,
   input  logic       Hsel,
   input  logic [1:0] Htrans,
   input  logic       Hready,
   output logic       Hready_out,
   output logic       Hresp,
   output logic [1:0] state_o
);

   def_state_e state_q, state_d;

   logic take_err;
   assign take_err = Hready && Hsel && is_active(Htrans);

   // State register; reset aborts any error response in flight.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) state_q <= DEF_OKAY;
      else          state_q <= state_d;
   end

   // Next state. Kept apart from the outputs so Hready_out never depends on Hready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DEF_OKAY: if (take_err) state_d = DEF_ERR1;
         DEF_ERR1: state_d = DEF_ERR2;
         DEF_ERR2: state_d = take_err ? DEF_ERR1 : DEF_OKAY;
         default:  state_d = DEF_OKAY;
      endcase
   end

   // Response outputs decoded purely from the current state.
   always_comb begin
      Hready_out = 1'b1;
      Hresp      = HRESP_OKAY;
      case (state_q)
         DEF_ERR1: begin
            Hready_out = 1'b0;
            Hresp      = HRESP_ERROR;
         end
         DEF_ERR2: Hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: region decode, data-phase select
// register and response/read-data mux, with a built-in default slave.
module ahb_lite_interconnect
   import ahb_lite_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = 3,
   parameter int REGION_LSB = 28,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                         Hclk,
   input  logic                         Hresetn,
   input  logic [ADDR_W-1:0]            Haddr,
   input  logic [1:0]                   Htrans,
   output logic                         Hready,
   output logic                         Hresp,
   output logic [DATA_W-1:0]            Hrdata,
   output logic [NUM_SLAVES-1:0]        Hsel_s,
   input  logic [NUM_SLAVES*DATA_W-1:0] Hrdata_s,
   input  logic [NUM_SLAVES-1:0]        Hready_out_s,
   input  logic [NUM_SLAVES-1:0]        Hresp_s,
   output logic [1:0]                   dbg_def_state_o
);

   logic [SEL_W-1:0] region;
   logic             unmapped;
   logic [SEL_W-1:0] sel_idx_q, sel_idx_d;
   logic             dflt_q, dflt_d;
   logic             def_ready, def_resp;

   // Only the region field takes part in decoding.
   logic unused_addr_bits;
   assign unused_addr_bits = ^Haddr;

   assign region = Haddr[REGION_LSB +: SEL_W];

   // One-hot decode; regions at or beyond NUM_SLAVES leave every select low.
   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
      assign Hsel_s[g] = (region == SEL_W'(g));
   end
   assign unmapped = ~|Hsel_s;

   assign sel_idx_d = Hready ? region   : sel_idx_q;
   assign dflt_d    = Hready ? unmapped : dflt_q;

   // Data-phase owner advances only when the current data phase completes.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         sel_idx_q <= '0;
         dflt_q    <= 1'b1;
      end else begin
         sel_idx_q <= sel_idx_d;
         dflt_q    <= dflt_d;
      end
   end

   ahb_default_slave u_default_slave (
      .Hclk       (Hclk),
      .Hresetn    (Hresetn),
      .Hsel       (unmapped),
      .Htrans     (Htrans),
      .Hready     (Hready),
      .Hready_out (def_ready),
      .Hresp      (def_resp),
      .state_o    (dbg_def_state_o)
   );

   // Return path mux: default slave unless a mapped slave owns the data phase.
   always_comb begin
      Hready = def_ready;
      Hresp  = def_resp;
      Hrdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!dflt_q && (sel_idx_q == SEL_W'(i))) begin
            Hready = Hready_out_s[i];
            Hresp  = Hresp_s[i];
            Hrdata = Hrdata_s[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Self-checking bench for ahb_lite_interconnect (default parameters, 4 slaves).
module tb_ahb_lite_interconnect;
   import ahb_lite_pkg::*;

   localparam int NS = 4;

   logic          Hclk;
   logic          Hresetn;
   logic [31:0]   Haddr;
   logic [1:0]    Htrans;
   logic          Hready;
   logic          Hresp;
   logic [31:0]   Hrdata;
   logic [NS-1:0] Hsel_s;
   logic [NS*32-1:0] Hrdata_s;
   logic [NS-1:0] Hready_out_s;
   logic [NS-1:0] Hresp_s;
   logic [1:0]    dbg_state;

   ahb_lite_interconnect dut (
      .Hclk            (Hclk),
      .Hresetn         (Hresetn),
      .Haddr           (Haddr),
      .Htrans          (Htrans),
      .Hready          (Hready),
      .Hresp           (Hresp),
      .Hrdata          (Hrdata),
      .Hsel_s          (Hsel_s),
      .Hrdata_s        (Hrdata_s),
      .Hready_out_s    (Hready_out_s),
      .Hresp_s         (Hresp_s),
      .dbg_def_state_o (dbg_state)
   );

   // Clock
   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: who owns the data phase (-1 = default slave) and how
   // many cycles into an error response the default slave is (0 = none).
   int          owner = -1;
   int          err_phase = 0;
   logic [31:0] slv_data [NS];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NS-1:0] exp_sel(input logic [31:0] addr);
      int r;
      r = int'(addr[30:28]);
      return (r < NS) ? (NS'(1) << r) : '0;
   endfunction

   function automatic logic [1:0] exp_state();
      case (err_phase)
         1:       return DEF_ERR1;
         2:       return DEF_ERR2;
         default: return DEF_OKAY;
      endcase
   endfunction

   // One bus cycle: drive, check mid-cycle, then advance the model at the edge.
   task automatic step(input logic [31:0] addr, input logic [1:0] trans,
                       input logic [NS-1:0] rdy, input logic [NS-1:0] resp);
      logic        e_ready, e_resp;
      logic [31:0] e_rdata;
      int          r;
      Haddr        = addr;
      Htrans       = trans;
      Hready_out_s = rdy;
      Hresp_s      = resp;
      for (int i = 0; i < NS; i++) begin
         slv_data[i] = $urandom;
         Hrdata_s[i*32 +: 32] = slv_data[i];
      end
      if (owner >= 0) begin
         e_ready = rdy[owner];
         e_resp  = resp[owner];
         e_rdata = slv_data[owner];
      end else begin
         e_ready = (err_phase != 1);
         e_resp  = (err_phase != 0);
         e_rdata = 32'h0;
      end
      @(negedge Hclk);
      chk("hsel", 32'(Hsel_s), 32'(exp_sel(addr)));
      chk("hready", 32'(Hready), 32'(e_ready));
      chk("hresp", 32'(Hresp), 32'(e_resp));
      chk("hrdata", Hrdata, e_rdata);
      chk("def_state", 32'(dbg_state), 32'(exp_state()));
      @(posedge Hclk);
      if (e_ready) begin
         r = int'(addr[30:28]);
         owner = (r < NS) ? r : -1;
         err_phase = (owner < 0 && trans[1]) ? 1 : 0;
      end else if (err_phase == 1) begin
         err_phase = 2;
      end
      #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [NS-1:0] rdy, rsp;
      // Reset with a NONSEQ to slave 1 already on the bus.
      Hresetn = 1'b0;
      Haddr = 32'h1000_0000;
      Htrans = HTRANS_NONSEQ;
      Hready_out_s = '1;
      Hresp_s = '0;
      Hrdata_s = '1;
      repeat (2) @(posedge Hclk);
      @(negedge Hclk);
      chk("rst_hready", 32'(Hready), 32'd1);
      chk("rst_hresp", 32'(Hresp), 32'd0);
      chk("rst_hrdata", Hrdata, 32'd0);
      chk("rst_hsel", 32'(Hsel_s), 32'b0010);
      chk("rst_state", 32'(dbg_state), 32'(DEF_OKAY));
      @(posedge Hclk); #1;
      Hresetn = 1'b1;

      // Mapped access to slave 1: zero-wait data phase.
      step(32'h1000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000);
      step(32'h0000_0040, HTRANS_IDLE, 4'b1111, 4'b0000);

      // Unmapped NONSEQ: ERR1 then ERR2 then OKAY.
      step(32'h5000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);

      // Slave 2 stalls three cycles while the next address targets slave 3.
      step(32'h2000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000);
      repeat (3) step(32'h3000_0000, HTRANS_NONSEQ, 4'b1011, 4'b0000);
      step(32'h3000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b1000);

      // IDLE and BUSY to unmapped regions stay OKAY.
      step(32'h7000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);
      step(32'h6000_0000, HTRANS_BUSY, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);

      // Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2, OKAY.
      step(32'h5000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000);
      step(32'h6000_0000, HTRANS_SEQ, 4'b1111, 4'b0000);
      step(32'h6000_0000, HTRANS_SEQ, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);

      // Reset pulsed during ERR1 must clear the error response at once.
      step(32'h7000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000);
      Htrans = HTRANS_IDLE;
      Haddr = 32'h0;
      #2;
      chk("err1_hready", 32'(Hready), 32'd0);
      chk("err1_hresp", 32'(Hresp), 32'd1);
      Hresetn = 1'b0;
      #1;
      chk("arst_hready", 32'(Hready), 32'd1);
      chk("arst_hresp", 32'(Hresp), 32'd0);
      chk("arst_state", 32'(dbg_state), 32'(DEF_OKAY));
      owner = -1;
      err_phase = 0;
      @(posedge Hclk); #1;
      Hresetn = 1'b1;
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);
      step(32'h0000_0000, HTRANS_IDLE, 4'b1111, 4'b0000);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         a = ($urandom & 32'h0FFF_FFFC) | (32'($urandom_range(0, 7)) << 28);
         for (int i = 0; i < NS; i++) begin
            rdy[i] = ($urandom_range(0, 3) != 0);
            rsp[i] = ($urandom_range(0, 7) == 0);
         end
         step(a, 2'($urandom_range(0, 3)), rdy, rsp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
